// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding, default operand width and counter sizing.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_comparator_cmp_bit_select.sv
// Combinational WIDTH:1 mux pair picking the operand bits under the scan counter.
module cmp_bit_select #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input  logic [WIDTH-1:0] a_q,
  input  logic [WIDTH-1:0] b_q,
  input  logic [CW-1:0]    cnt,
  output logic             a_bit,
  output logic             b_bit
);

  always_comb begin
    a_bit = a_q[cnt];
    b_bit = b_q[cnt];
  end

endmodule

// File: rtl/seq_comparator.sv
// MSB-first bit-serial magnitude comparator with start/done handshake.
// Stops at the first differing bit; signed mode inverts the sign-bit decision.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] MSB_IDX = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic             a_bit;
  logic             b_bit;

  cmp_bit_select #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_select (
    .a_q   (a_q),
    .b_q   (b_q),
    .cnt   (cnt),
    .a_bit (a_bit),
    .b_bit (b_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            sm_q  <= signed_mode;
            cnt   <= MSB_IDX;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            state <= SCAN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (a_bit != b_bit) begin
            // A set sign bit means the smaller value in two's complement.
            if (cnt == MSB_IDX && sm_q) begin
              gt <= b_bit;
              lt <= a_bit;
            end else begin
              gt <= a_bit;
              lt <= b_bit;
            end
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            eq    <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Multi-cycle, MSB-first bit-serial magnitude comparator with a start/done handshake.
- Produces mutually exclusive gt/eq/lt flags for signed or unsigned operands.
- Consumer is the branch/set-condition path, which needs all three relations, not only A > B.
- Trades latency for a single-bit datapath; terminates early at the first differing bit.

Parameters:
WIDTH, 16, operand width in bits (>= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
A  input  WIDTH  operand A; latched with start
B  input  WIDTH  operand B; latched with start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse: result valid
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- One clock domain; reset is asynchronous and active-low; clk and rst_n as named above.
- Reset (any time, including mid-scan): state=IDLE; busy, done, gt, eq, lt = 0; counter and operand registers cleared. Scan in progress is discarded.
- States:
  - IDLE: waiting for work.
  - SCAN: examining one bit per cycle.
  - DONE: one cycle; asserts done.
- Acceptance:
  - start=1 in IDLE or DONE latches A, B, signed_mode.
  - Sets cnt=WIDTH-1, clears gt/eq/lt, and enters SCAN.
  - start while in SCAN is ignored; there is no queueing.
- SCAN, each cycle, compares a=A_q[cnt] and b=B_q[cnt]:
  - If a != b and cnt==WIDTH-1 and signed_mode=1: gt = b, lt = a (sign bit inverted). Go to DONE.
  - If a != b otherwise: gt = a, lt = b. Go to DONE.
  - If a == b and cnt==0: eq=1. Go to DONE.
  - Otherwise: cnt = cnt-1 and remain in SCAN.
- busy=1 exactly while state==SCAN.
- DONE:
  - done=1 for this single cycle.
  - Next state is SCAN if start=1, else IDLE.
- Result hold: gt/eq/lt stay stable from DONE until the next acceptance (or reset).
- Invariant: at most one of gt/eq/lt is high; exactly one is high whenever done=1.
- Latency:
  - Let k = index of the highest differing bit (k=0 if A==B).
  - Accept edge is cycle 0; done is high in cycle WIDTH+1-k.
  - Range: 2 (MSB differs) to WIDTH+1.
- Back-to-back: start held high through DONE gives one idle-free restart per result.
- Operand inputs are don't-care except on the acceptance cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, SCAN=2'b01, DONE=2'b10;
  - default WIDTH constant;
  - counter width as clog2(WIDTH).
- One sub-module, cmp_bit_select: combinational WIDTH:1 mux pair returning A_q[cnt] and B_q[cnt].
- FSM, counter, and flag registers stay in the top level.

Test Plan:
1. Signed, A=16'h0001, B=16'hFFFF, start for 1 cycle -> gt=1, eq=0, lt=0; done pulses in cycle 2; busy high cycle 1 only.
2. Unsigned, same A/B -> lt=1; done in cycle 2.
3. Unsigned, A=16'h1234, B=16'h1234 -> eq=1; done in cycle 17; busy high cycles 1-16; flags held after done until next start.
4. Unsigned, A=16'h0003, B=16'h0002 -> gt=1 in cycle 17 (k=0). Then start held high through DONE with A=16'h8000, B=16'h7FFF, signed -> lt=1 two cycles later, with no IDLE cycle between.
5. start pulsed again in cycle 5 of a scan of 16'h0000 vs 16'h0000 with different operands presented -> ignored; eq=1 reported in cycle 17 for the original operands.
6. rst_n driven low in cycle 6 of a scan -> busy, done, gt, eq, lt = 0 immediately (asynchronous); after release, IDLE with no done pulse until a new start.
